// File: rtl/hazard_scoreboard_if.sv
// Issue, forwarding and pipeline-control bundle between decode and the hazard scoreboard.
// The master drives instruction and stage information; the slave returns the stall and forward controls.
interface hazard_scoreboard_if #(
  parameter int NREGS = 32,
  parameter int AW    = 5,
  parameter int NFWD  = 2,
  parameter int LAT_W = 4,
  parameter int CNT_W = 16
);
  localparam int SW = $clog2(NFWD + 1);

  logic              iIssue_valid;
  logic [AW-1:0]     iIssue_rs1;
  logic [AW-1:0]     iIssue_rs2;
  logic              iIssue_rs1_used;
  logic              iIssue_rs2_used;
  logic [AW-1:0]     iIssue_rd;
  logic              iIssue_wr;
  logic [LAT_W-1:0]  iIssue_lat;
  logic [NFWD-1:0]   iFw_valid;
  logic [NFWD*AW-1:0] iFw_rd;
  logic [NFWD-1:0]   iFw_ready;
  logic              iBrTrue;
  logic              iStall_mem;
  logic              iStall_dbg;

  logic              oStall_IF;
  logic              oStall_ID;
  logic              oStall_EX;
  logic              oStall_ME;
  logic              oBubble_EX;
  logic [SW-1:0]     oFwS1_sel;
  logic [SW-1:0]     oFwS2_sel;
  logic              oFlush_IF;
  logic              oFlush_ID;
  logic [NREGS-1:0]  oPending;
  logic [CNT_W-1:0]  oStallCnt;

  modport master (
    output iIssue_valid, iIssue_rs1, iIssue_rs2, iIssue_rs1_used, iIssue_rs2_used,
    output iIssue_rd, iIssue_wr, iIssue_lat,
    output iFw_valid, iFw_rd, iFw_ready,
    output iBrTrue, iStall_mem, iStall_dbg,
    input  oStall_IF, oStall_ID, oStall_EX, oStall_ME, oBubble_EX,
    input  oFwS1_sel, oFwS2_sel, oFlush_IF, oFlush_ID, oPending, oStallCnt
  );

  modport slave (
    input  iIssue_valid, iIssue_rs1, iIssue_rs2, iIssue_rs1_used, iIssue_rs2_used,
    input  iIssue_rd, iIssue_wr, iIssue_lat,
    input  iFw_valid, iFw_rd, iFw_ready,
    input  iBrTrue, iStall_mem, iStall_dbg,
    output oStall_IF, oStall_ID, oStall_EX, oStall_ME, oBubble_EX,
    output oFwS1_sel, oFwS2_sel, oFlush_IF, oFlush_ID, oPending, oStallCnt
  );
endinterface

// File: rtl/hazard_scoreboard.sv
// Per-register write scoreboard with countdown timers, plus forwarding-select, stall,
// bubble and flush generation for the IF/ID/EX/ME pipeline.
module hazard_scoreboard #(
  parameter int NREGS = 32,
  parameter int AW    = 5,
  parameter int NFWD  = 2,
  parameter int LAT_W = 4,
  parameter int CNT_W = 16
) (
  input  logic iClk,
  input  logic iRst,
  hazard_scoreboard_if.slave bus
);
  localparam int SW = $clog2(NFWD + 1);

  logic [NREGS-1:0] pending_q, pending_d;
  logic [LAT_W-1:0] cnt_q [NREGS];
  logic [LAT_W-1:0] cnt_d [NREGS];
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

  logic [SW:0]   rs1_res, rs2_res;
  logic          rs1_haz, rs2_haz, waw_haz;
  logic [SW-1:0] rs1_sel, rs2_sel;
  logic          haz, hold, issue, track;

  // Returns {hazard, select}; the youngest matching stage wins even when it is not ready yet.
  function automatic logic [SW:0] src_lookup(
    input logic [AW-1:0]      rs,
    input logic               used,
    input logic [NFWD-1:0]    fw_valid,
    input logic [NFWD*AW-1:0] fw_rd,
    input logic [NFWD-1:0]    fw_ready,
    input logic [NREGS-1:0]   pend
  );
    logic          hit, rdy, src_haz;
    logic [SW-1:0] hit_sel, sel;
    hit     = 1'b0;
    rdy     = 1'b0;
    hit_sel = '0;
    src_haz = 1'b0;
    sel     = '0;
    for (int i = NFWD - 1; i >= 0; i--) begin
      if (fw_valid[i] && (fw_rd[i*AW +: AW] == rs)) begin
        hit     = 1'b1;
        rdy     = fw_ready[i];
        hit_sel = SW'(i + 1);
      end
    end
    if (used && (rs != '0)) begin
      if (hit) begin
        src_haz = ~rdy;
        sel     = rdy ? hit_sel : '0;
      end else begin
        src_haz = pend[rs];
      end
    end
    return {src_haz, sel};
  endfunction

  always_comb begin
    rs1_res = src_lookup(bus.iIssue_rs1, bus.iIssue_rs1_used, bus.iFw_valid,
                         bus.iFw_rd, bus.iFw_ready, pending_q);
    rs2_res = src_lookup(bus.iIssue_rs2, bus.iIssue_rs2_used, bus.iFw_valid,
                         bus.iFw_rd, bus.iFw_ready, pending_q);
  end

  assign rs1_haz = rs1_res[SW];
  assign rs1_sel = rs1_res[SW-1:0];
  assign rs2_haz = rs2_res[SW];
  assign rs2_sel = rs2_res[SW-1:0];

  // A new write may only issue once the older one would land no later than it.
  assign waw_haz = bus.iIssue_wr && (bus.iIssue_rd != '0) && pending_q[bus.iIssue_rd]
                   && (cnt_q[bus.iIssue_rd] > bus.iIssue_lat);

  assign haz   = bus.iIssue_valid && (rs1_haz || rs2_haz || waw_haz);
  assign hold  = bus.iStall_mem || bus.iStall_dbg;
  assign issue = bus.iIssue_valid && !haz && !hold && !bus.iBrTrue;
  assign track = bus.iIssue_wr && (bus.iIssue_rd != '0) && (bus.iIssue_lat != '0);

  always_comb begin
    pending_d   = pending_q;
    cnt_d       = cnt_q;
    stall_cnt_d = stall_cnt_q;
    if (!hold) begin
      for (int r = 1; r < NREGS; r++) begin
        if (pending_q[r]) begin
          if (cnt_q[r] == LAT_W'(1)) begin
            pending_d[r] = 1'b0;
            cnt_d[r]     = '0;
          end else begin
            cnt_d[r] = cnt_q[r] - LAT_W'(1);
          end
        end
      end
      if (haz && (stall_cnt_q != '1)) begin
        stall_cnt_d = stall_cnt_q + CNT_W'(1);
      end
    end
    // Applied after retirement so a same-cycle reissue keeps the entry alive.
    if (issue && track) begin
      pending_d[bus.iIssue_rd] = 1'b1;
      cnt_d[bus.iIssue_rd]     = bus.iIssue_lat;
    end
  end

  always_ff @(posedge iClk) begin
    if (iRst) begin
      pending_q   <= '0;
      stall_cnt_q <= '0;
      for (int r = 0; r < NREGS; r++) begin
        cnt_q[r] <= '0;
      end
    end else begin
      pending_q   <= pending_d;
      stall_cnt_q <= stall_cnt_d;
      for (int r = 0; r < NREGS; r++) begin
        cnt_q[r] <= cnt_d[r];
      end
    end
  end

  assign bus.oStall_IF  = !iRst && (haz || hold);
  assign bus.oStall_ID  = !iRst && (haz || hold);
  assign bus.oStall_EX  = !iRst && hold;
  assign bus.oStall_ME  = !iRst && hold;
  assign bus.oBubble_EX = !iRst && haz && !hold && !bus.iBrTrue;
  assign bus.oFwS1_sel  = iRst ? '0 : rs1_sel;
  assign bus.oFwS2_sel  = iRst ? '0 : rs2_sel;
  assign bus.oFlush_IF  = iRst || bus.iBrTrue;
  assign bus.oFlush_ID  = iRst || bus.iBrTrue;
  assign bus.oPending   = pending_q;
  assign bus.oStallCnt  = stall_cnt_q;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed and randomized bench for hazard_scoreboard against a remaining-cycles reference model.
module tb_hazard_scoreboard;
  localparam int NREGS   = 32;
  localparam int AW      = 5;
  localparam int NFWD    = 2;
  localparam int LAT_W   = 4;
  localparam int CNT_W   = 6;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  hazard_scoreboard_if #(.NREGS(NREGS), .AW(AW), .NFWD(NFWD), .LAT_W(LAT_W), .CNT_W(CNT_W)) hif ();

  hazard_scoreboard #(.NREGS(NREGS), .AW(AW), .NFWD(NFWD), .LAT_W(LAT_W), .CNT_W(CNT_W)) dut (
    .iClk(clk),
    .iRst(rst),
    .bus (hif)
  );

  int n_checks = 0;
  int n_pass   = 0;
  int rem [NREGS];
  int scnt;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
  endtask

  // Youngest matching stage decides; otherwise an outstanding write means wait.
  task automatic src_model(input logic [AW-1:0] rs, input logic used, output logic h, output int sel);
    logic found;
    h = 1'b0;
    sel = 0;
    found = 1'b0;
    if (used && rs != 0) begin
      for (int i = 0; i < NFWD && !found; i++) begin
        if (hif.iFw_valid[i] && hif.iFw_rd[i*AW +: AW] == rs) begin
          found = 1'b1;
          if (hif.iFw_ready[i]) sel = i + 1;
          else h = 1'b1;
        end
      end
      if (!found) h = (rem[rs] > 0);
    end
  endtask

  task automatic idle();
    hif.iIssue_valid = 0; hif.iIssue_rs1 = 0; hif.iIssue_rs2 = 0;
    hif.iIssue_rs1_used = 0; hif.iIssue_rs2_used = 0;
    hif.iIssue_rd = 0; hif.iIssue_wr = 0; hif.iIssue_lat = 0;
    hif.iFw_valid = 0; hif.iFw_rd = 0; hif.iFw_ready = 0;
    hif.iBrTrue = 0; hif.iStall_mem = 0; hif.iStall_dbg = 0;
  endtask

  task automatic adv();
    @(posedge clk);
    #1;
  endtask

  // Compare all outputs with the model for the current inputs, then step the model.
  task automatic eval();
    logic h1, h2, waw, haz, hold;
    int s1, s2;
    logic [NREGS-1:0] pend;
    #4;
    src_model(hif.iIssue_rs1, hif.iIssue_rs1_used, h1, s1);
    src_model(hif.iIssue_rs2, hif.iIssue_rs2_used, h2, s2);
    waw  = hif.iIssue_wr && hif.iIssue_rd != 0 && rem[hif.iIssue_rd] > int'(hif.iIssue_lat);
    haz  = hif.iIssue_valid && (h1 || h2 || waw);
    hold = hif.iStall_mem || hif.iStall_dbg;
    for (int r = 0; r < NREGS; r++) pend[r] = (rem[r] > 0);
    check("pending",  hif.oPending, pend);
    check("stallcnt", hif.oStallCnt, scnt);
    check("stall_if", hif.oStall_IF, !rst && (haz || hold));
    check("stall_id", hif.oStall_ID, !rst && (haz || hold));
    check("stall_ex", hif.oStall_EX, !rst && hold);
    check("stall_me", hif.oStall_ME, !rst && hold);
    check("bubble",   hif.oBubble_EX, !rst && haz && !hold && !hif.iBrTrue);
    check("sel1",     hif.oFwS1_sel, rst ? 0 : s1);
    check("sel2",     hif.oFwS2_sel, rst ? 0 : s2);
    check("flush_if", hif.oFlush_IF, rst || hif.iBrTrue);
    check("flush_id", hif.oFlush_ID, rst || hif.iBrTrue);
    if (rst) begin
      for (int r = 0; r < NREGS; r++) rem[r] = 0;
      scnt = 0;
    end else if (!hold) begin
      for (int r = 0; r < NREGS; r++) if (rem[r] > 0) rem[r]--;
      if (haz && scnt < CNT_MAX) scnt++;
      if (hif.iIssue_valid && !haz && !hif.iBrTrue && hif.iIssue_wr &&
          hif.iIssue_rd != 0 && hif.iIssue_lat != 0)
        rem[hif.iIssue_rd] = hif.iIssue_lat;
    end
  endtask

  task automatic issue_wr(input int rd, input int lat);
    idle();
    hif.iIssue_valid = 1; hif.iIssue_wr = 1;
    hif.iIssue_rd = AW'(rd); hif.iIssue_lat = LAT_W'(lat);
  endtask

  // Counts consecutive stalled cycles, bounded so a stuck hazard still ends the run.
  task automatic count_stalls(output int n);
    n = 0;
    for (int k = 0; k < 20; k++) begin
      eval();
      if (!hif.oStall_ID) break;
      n++;
      adv();
    end
    adv();
  endtask

  initial begin
    int n, s0;
    for (int r = 0; r < NREGS; r++) rem[r] = 0;
    scnt = 0;
    rst = 1;
    idle();
    adv();
    eval();
    check("rst_flush", hif.oFlush_ID, 1);
    adv();
    rst = 0;

    // load-use then ready forward
    idle();
    hif.iFw_valid = 2'b01; hif.iFw_rd[AW-1:0] = 5;
    hif.iIssue_valid = 1; hif.iIssue_rs1 = 5; hif.iIssue_rs1_used = 1;
    eval();
    check("lu_stall", hif.oStall_ID, 1);
    check("lu_bubble", hif.oBubble_EX, 1);
    adv();
    hif.iFw_ready = 2'b01;
    eval();
    check("lu_sel", hif.oFwS1_sel, 1);
    check("lu_nostall", hif.oStall_ID, 0);
    adv();

    // priority: youngest stage wins; r0 never forwards
    idle();
    hif.iFw_valid = 2'b11; hif.iFw_ready = 2'b11;
    hif.iFw_rd[AW-1:0] = 7; hif.iFw_rd[2*AW-1:AW] = 7;
    hif.iIssue_valid = 1; hif.iIssue_rs2 = 7; hif.iIssue_rs2_used = 1;
    eval();
    check("prio_sel", hif.oFwS2_sel, 1);
    adv();
    hif.iIssue_rs2 = 0;
    hif.iFw_rd[AW-1:0] = 0; hif.iFw_rd[2*AW-1:AW] = 0;
    eval();
    check("r0_sel", hif.oFwS2_sel, 0);
    check("r0_nostall", hif.oStall_ID, 0);
    adv();

    // scoreboard countdown
    issue_wr(9, 3);
    eval(); adv();
    idle();
    hif.iIssue_valid = 1; hif.iIssue_rs1 = 9; hif.iIssue_rs1_used = 1;
    count_stalls(n);
    check("sb_stalls", n, 3);
    check("sb_cleared", hif.oPending[9], 0);

    // WAW then same-cycle retire/reissue
    issue_wr(4, 5);
    eval(); adv();
    issue_wr(4, 2);
    count_stalls(n);
    check("waw_stalls", n, 3);
    idle();
    eval(); adv();
    issue_wr(4, 3);
    eval();
    check("reissue_ok", hif.oStall_ID, 0);
    adv();
    check("reissue_pend", hif.oPending[4], 1);

    // hold freezes the countdown and the stall counter
    issue_wr(10, 4);
    eval(); adv();
    idle();
    hif.iIssue_valid = 1; hif.iIssue_rs1 = 10; hif.iIssue_rs1_used = 1;
    hif.iStall_mem = 1;
    s0 = scnt;
    repeat (4) begin
      eval();
      check("hold_ex", hif.oStall_EX, 1);
      adv();
    end
    check("hold_cnt", hif.oStallCnt, s0);
    hif.iStall_mem = 0;
    count_stalls(n);
    check("hold_resume", n, 4);

    // branch during hazard, then reset mid-operation
    issue_wr(11, 3);
    eval(); adv();
    idle();
    hif.iIssue_valid = 1; hif.iIssue_rs1 = 11; hif.iIssue_rs1_used = 1; hif.iBrTrue = 1;
    eval();
    check("br_flush", hif.oFlush_IF, 1);
    check("br_bubble", hif.oBubble_EX, 0);
    adv();
    idle();
    check("br_keep", hif.oPending[11], 1);
    rst = 1;
    eval();
    check("rst_flush_if", hif.oFlush_IF, 1);
    adv();
    check("rst_pend", hif.oPending, 0);
    check("rst_cnt", hif.oStallCnt, 0);
    rst = 0;

    // stall counter saturation
    idle();
    hif.iFw_valid = 2'b01; hif.iFw_rd[AW-1:0] = 3;
    hif.iIssue_valid = 1; hif.iIssue_rs1 = 3; hif.iIssue_rs1_used = 1;
    repeat (CNT_MAX + 8) begin eval(); adv(); end
    check("sat_cnt", hif.oStallCnt, CNT_MAX);

    // randomized traffic
    for (int c = 0; c < 3000; c++) begin
      rst = ($urandom_range(127) == 0);
      hif.iIssue_valid = $urandom_range(3) != 0;
      hif.iIssue_rs1 = AW'($urandom_range(7));
      hif.iIssue_rs2 = AW'($urandom_range(7));
      hif.iIssue_rs1_used = $urandom_range(1);
      hif.iIssue_rs2_used = $urandom_range(1);
      hif.iIssue_rd = AW'($urandom_range(7));
      hif.iIssue_wr = $urandom_range(1);
      hif.iIssue_lat = LAT_W'($urandom_range(6));
      hif.iFw_valid = NFWD'($urandom);
      hif.iFw_ready = NFWD'($urandom);
      for (int i = 0; i < NFWD; i++) hif.iFw_rd[i*AW +: AW] = AW'($urandom_range(7));
      hif.iBrTrue = ($urandom_range(7) == 0);
      hif.iStall_mem = ($urandom_range(9) == 0);
      hif.iStall_dbg = ($urandom_range(19) == 0);
      eval();
      adv();
    end
    rst = 0;
    idle();
    eval();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
